// File: rtl/cart_rom_mbc1.sv
// rtl/cart_rom_mbc1.sv - MBC1-style cartridge ROM bank mapper with a pipelined multi-block ROM read path
module cart_rom_mbc1 #(
  parameter int NUM_BLOCKS = 4,
  parameter int BLK_AW     = 16,
  parameter int ROM_LAT    = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [15:0]                            a,
  input  logic [7:0]                             din,
  input  logic                                   wr,
  input  logic                                   rd,
  output logic [7:0]                             dout,
  output logic                                   dout_valid,
  output logic [BLK_AW-1:0]                      blk_addr,
  input  logic [NUM_BLOCKS*8-1:0]                blk_dout,
  output logic                                   ram_en,
  output logic [1:0]                             ram_bank,
  output logic [BLK_AW+$clog2(NUM_BLOCKS)-15:0] rom_bank
);

  localparam int BLK_W  = $clog2(NUM_BLOCKS);
  localparam int ROM_AW = BLK_AW + BLK_W;
  localparam int BANK_W = ROM_AW - 14;
  localparam int IDX_W  = (BLK_W > 0) ? BLK_W : 1;

  logic [4:0]        low;
  logic [1:0]        upper;
  logic              mode;
  logic [4:0]        low5;
  logic [6:0]        bank;
  logic [ROM_AW-1:0] phys;
  logic [IDX_W-1:0]  blk_idx;
  logic              acc_rd;
  logic              acc_wr;
  logic              unused_din;

  logic [ROM_LAT-1:0] vld_pipe;
  logic [IDX_W-1:0]   idx_pipe [ROM_LAT];

  assign acc_rd     = rd & ~a[15];
  assign acc_wr     = wr & ~a[15];
  assign unused_din = ^din[7:5];

  // Bank register value 0 maps to 1; only the 5-bit low field is tested.
  assign low5 = (low == 5'd0) ? 5'd1 : low;

  always_comb begin
    bank = 7'd0;
    if (a[14])
      bank = {upper, low5};
    else if (mode)
      bank = {upper, 5'b0};
  end

  // Bank bits beyond the ROM size simply wrap.
  assign phys     = ROM_AW'({bank, a[13:0]});
  assign blk_addr = phys[BLK_AW-1:0];
  assign blk_idx  = IDX_W'(phys >> BLK_AW);

  assign rom_bank = BANK_W'({upper, low5});
  assign ram_bank = mode ? upper : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low    <= 5'd0;
      upper  <= 2'd0;
      mode   <= 1'b0;
      ram_en <= 1'b0;
    end else if (acc_wr) begin
      case (a[14:13])
        2'd0: ram_en <= (din[3:0] == 4'hA);
        2'd1: low    <= din[4:0];
        2'd2: upper  <= din[1:0];
        2'd3: mode   <= din[0];
        default: ;
      endcase
    end
  end

  // Block index travels alongside the read strobe to pick the byte once the ROM answers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < ROM_LAT; i++)
        idx_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= acc_rd;
      idx_pipe[0] <= blk_idx;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  assign dout_valid = vld_pipe[ROM_LAT-1];
  assign dout       = dout_valid ? blk_dout[8*idx_pipe[ROM_LAT-1] +: 8] : 8'hFF;

endmodule

// File: tb/tb_cart_rom_mbc1.sv
// tb/tb_cart_rom_mbc1.sv - directed bench for cart_rom_mbc1 in default and 16-block/2-cycle configurations
module tb_cart_rom_mbc1;

  logic clk;
  logic rst_n;

  logic [15:0]  a_a, a_b;
  logic [7:0]   din_a, din_b;
  logic         wr_a, wr_b, rd_a, rd_b;
  logic [7:0]   dout_a, dout_b;
  logic         dout_valid_a, dout_valid_b;
  logic [15:0]  blk_addr_a, blk_addr_b;
  logic [31:0]  blk_dout_a;
  logic [127:0] blk_dout_b;
  logic [127:0] rom_b1;
  logic         ram_en_a, ram_en_b;
  logic [1:0]   ram_bank_a, ram_bank_b;
  logic [3:0]   rom_bank_a;
  logic [5:0]   rom_bank_b;

  int checks = 0;
  int errors = 0;

  cart_rom_mbc1 #(.NUM_BLOCKS(4), .BLK_AW(16), .ROM_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .a(a_a), .din(din_a), .wr(wr_a), .rd(rd_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .blk_addr(blk_addr_a),
    .blk_dout(blk_dout_a), .ram_en(ram_en_a), .ram_bank(ram_bank_a), .rom_bank(rom_bank_a)
  );

  cart_rom_mbc1 #(.NUM_BLOCKS(16), .BLK_AW(16), .ROM_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .a(a_b), .din(din_b), .wr(wr_b), .rd(rd_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .blk_addr(blk_addr_b),
    .blk_dout(blk_dout_b), .ram_en(ram_en_b), .ram_bank(ram_bank_b), .rom_bank(rom_bank_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM block i returns addr[7:0] ^ {i, 4'h5}
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      blk_dout_a[8*i +: 8] <= blk_addr_a[7:0] ^ (8'(i * 16) | 8'h05);
    for (int j = 0; j < 16; j++)
      rom_b1[8*j +: 8] <= blk_addr_b[7:0] ^ (8'(j * 16) | 8'h05);
    blk_dout_b <= rom_b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit b, input logic [15:0] addr, input logic [7:0] data,
                       input bit r, input bit w);
    @(negedge clk);
    if (b) begin
      a_b = addr; din_b = data; rd_b = r; wr_b = w;
    end else begin
      a_a = addr; din_a = data; rd_a = r; wr_a = w;
    end
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
    #1;
  endtask

  task automatic wr_op(input bit b, input logic [15:0] addr, input logic [7:0] data);
    drive(b, addr, data, 1'b0, 1'b1);
    idle();
  endtask

  initial begin
    bit seen;
    rst_n = 1'b1;
    a_a = '0; din_a = '0; wr_a = 1'b0; rd_a = 1'b0;
    a_b = '0; din_b = '0; wr_b = 1'b0; rd_b = 1'b0;
    #3 rst_n = 1'b0;
    @(negedge clk); #1;
    check("rst_dout", dout_a, 8'hFF);
    check("rst_valid", dout_valid_a, 1'b0);
    check("rst_ram_en", ram_en_a, 1'b0);
    check("rst_ram_bank", ram_bank_a, 2'd0);
    check("rst_rom_bank", rom_bank_a, 4'd1);
    check("rst_rom_bank_b", rom_bank_b, 6'd1);
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 16'h4123, 8'h00, 1, 0);
    check("rd4123_addr", blk_addr_a, 16'h4123);
    check("rd4123_early", dout_valid_a, 1'b0);
    idle();
    check("rd4123_valid", dout_valid_a, 1'b1);
    check("rd4123_dout", dout_a, 8'h26);
    idle();
    check("rd4123_drop", dout_valid_a, 1'b0);
    check("rd4123_idle", dout_a, 8'hFF);

    wr_op(0, 16'h2100, 8'h0D);
    check("bank13", rom_bank_a, 4'd13);
    drive(0, 16'h7FFF, 8'h00, 1, 0);
    check("rd7fff_addr", blk_addr_a, 16'h7FFF);
    idle();
    check("rd7fff_dout", dout_a, 8'hCA);
    idle();

    wr_op(0, 16'h2000, 8'h00);
    check("low0", rom_bank_a, 4'd1);
    wr_op(0, 16'h2000, 8'h20);
    check("low20", rom_bank_a, 4'd1);
    wr_op(0, 16'h2000, 8'h1F);
    check("low1f_wrap", rom_bank_a, 4'd15);
    drive(0, 16'h4000, 8'h00, 1, 0);
    check("rd4000_addr", blk_addr_a, 16'hC000);
    idle();
    check("rd4000_dout", dout_a, 8'h35);
    idle();

    drive(0, 16'h0123, 8'h00, 1, 0);
    drive(0, 16'h7F42, 8'h00, 1, 0);
    check("b2b_first", dout_a, 8'h26);
    idle();
    check("b2b_second_v", dout_valid_a, 1'b1);
    check("b2b_second", dout_a, 8'h77);
    idle();
    check("b2b_end", dout_valid_a, 1'b0);

    wr_op(0, 16'h0000, 8'h0A);
    check("ram_en_0a", ram_en_a, 1'b1);
    wr_op(0, 16'h0000, 8'h1A);
    check("ram_en_1a", ram_en_a, 1'b1);
    wr_op(0, 16'h0000, 8'h0B);
    check("ram_en_0b", ram_en_a, 1'b0);
    wr_op(0, 16'h8000, 8'h0A);
    check("ram_en_hi", ram_en_a, 1'b0);
    drive(0, 16'h8000, 8'h00, 1, 0);
    idle();
    check("rd_hi_ignored", dout_valid_a, 1'b0);

    wr_op(1, 16'h4000, 8'h01);
    wr_op(1, 16'h6000, 8'h01);
    check("b_ram_bank", ram_bank_b, 2'd1);
    check("b_rom_bank", rom_bank_b, 6'h21);
    drive(1, 16'h0010, 8'h00, 1, 0);
    check("b_rd_addr", blk_addr_b, 16'h0010);
    idle();
    check("b_lat1_valid", dout_valid_b, 1'b0);
    check("b_lat1_dout", dout_b, 8'hFF);
    idle();
    check("b_lat2_valid", dout_valid_b, 1'b1);
    check("b_lat2_dout", dout_b, 8'h95);
    idle();
    check("b_lat3_valid", dout_valid_b, 1'b0);

    drive(1, 16'h4000, 8'h02, 1, 1);
    check("rw_addr", blk_addr_b, 16'h4000);
    idle();
    check("rw_ram_bank", ram_bank_b, 2'd2);
    idle();
    check("rw_valid", dout_valid_b, 1'b1);
    check("rw_dout", dout_b, 8'h85);
    idle();

    wr_op(0, 16'h0000, 8'h0A);
    check("pre_rst_ram_en", ram_en_a, 1'b1);
    drive(1, 16'h0010, 8'h00, 1, 0);
    idle();
    rst_n = 1'b0;
    #1;
    check("inrst_valid_b", dout_valid_b, 1'b0);
    check("inrst_dout_b", dout_b, 8'hFF);
    check("inrst_ram_bank_b", ram_bank_b, 2'd0);
    check("inrst_rom_bank_b", rom_bank_b, 6'd1);
    check("inrst_ram_en_a", ram_en_a, 1'b0);
    check("inrst_rom_bank_a", rom_bank_a, 4'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (dout_valid_b || dout_valid_a) seen = 1'b1;
    end
    check("flushed_read", seen, 1'b0);
    check("post_rst_dout_b", dout_b, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_rom_mbc1.md
CART_ROM_MBC1 -- requirements
Module: cart_rom_mbc1

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 4, number of ROM blocks (power of two, >=1).
REQ-002 SHALL have parameter BLK_AW, default 16, address width of each ROM block (>=14).
REQ-003 SHALL have parameter ROM_LAT, default 1, read latency of the ROM blocks in cycles (>=1).
REQ-004 SHALL derive ROM_AW = BLK_AW + log2(NUM_BLOCKS) and NBANK = 2^(ROM_AW-14) 16 KB banks.
REQ-005 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: a  in  16  CPU address.
REQ-008 SHALL have port: din  in  8  CPU write data.
REQ-009 SHALL have port: wr  in  1  one-cycle write strobe.
REQ-010 SHALL have port: rd  in  1  one-cycle read strobe.
REQ-011 SHALL have port: dout  out  8  read data.
REQ-012 SHALL have port: dout_valid  out  1  dout qualifier, one-cycle pulse.
REQ-013 SHALL have port: blk_addr  out  BLK_AW  address driven to all ROM blocks.
REQ-014 SHALL have port: blk_dout  in  NUM_BLOCKS*8  concatenated block outputs; block i on bits [8i+7:8i].
REQ-015 SHALL have port: ram_en  out  1  cartridge RAM enable.
REQ-016 SHALL have port: ram_bank  out  2  cartridge RAM bank.
REQ-017 SHALL have port: rom_bank  out  ROM_AW-14  effective bank for 0x4000-0x7FFF (debug).

Function
REQ-018 SHALL act on wr or rd only when a[15]=0; other accesses are ignored (no state change, no dout_valid).
REQ-019 SHALL decode writes: 0x0000-0x1FFF ram_en <= (din[3:0]==4'hA); 0x2000-0x3FFF low <= din[4:0]; 0x4000-0x5FFF upper <= din[1:0]; 0x6000-0x7FFF mode <= din[0].
REQ-020 SHALL substitute low5 = 1 when low==0, else low (zero check on 5 bits only).
REQ-021 SHALL select bank = mode ? {upper,5'b0} : 0 for a[14]=0, and bank = {upper,low5} for a[14]=1.
REQ-022 SHALL form phys = {bank, a[13:0]} truncated to ROM_AW bits (higher bank bits wrap, no error).
REQ-023 SHALL drive blk_addr = phys[BLK_AW-1:0] combinationally; block index = phys[ROM_AW-1:BLK_AW] (0 when NUM_BLOCKS=1).
REQ-024 SHALL delay the block index and rd through a ROM_LAT-stage pipeline; dout_valid asserts exactly ROM_LAT cycles after an accepted rd.
REQ-025 SHALL output dout = selected blk_dout byte while dout_valid=1, else 8'hFF.
REQ-026 SHALL accept back-to-back rd every cycle, returning each result in order.
REQ-027 SHALL on simultaneous rd and wr compute the read with pre-write register values; the write takes effect next cycle.
REQ-028 SHALL drive ram_bank = mode ? upper : 2'b00 and rom_bank = {upper,low5} truncated to ROM_AW-14 bits.

Reset
REQ-029 SHALL on rst_n=0 asynchronously clear low, upper, mode, ram_en and all pipeline stages.
REQ-030 SHALL hold during reset: dout=8'hFF, dout_valid=0, ram_en=0, ram_bank=0, rom_bank=1.
REQ-031 SHALL discard any read in flight when reset asserts; no dout_valid is produced for it after release.

Verification
REQ-032 SHALL cover: after reset, rd a=0x4123 -> blk_addr=0x4123, block 0, dout_valid 1 cycle later, dout = blk0 byte.
REQ-033 SHALL cover: wr a=0x2100 din=0x0D, then rd a=0x7FFF -> phys 0x37FFF, block 3, blk_addr=0x7FFF, rom_bank=13.
REQ-034 SHALL cover: wr a=0x2000 din=0x00 -> rom_bank=1; din=0x20 -> rom_bank=1; din=0x1F -> bank 31 wraps to 15, rd 0x4000 -> phys 0x3C000.
REQ-035 SHALL cover: wr a=0x0000 din=0x0A -> ram_en=1; din=0x1A -> ram_en=1; din=0x0B -> ram_en=0; wr a=0x8000 din=0x0A -> unchanged.
REQ-036 SHALL cover, NUM_BLOCKS=16, ROM_LAT=2: wr 0x4000 din=0x01, wr 0x6000 din=0x01, rd 0x0010 -> phys 0x80010, block 8, ram_bank=1, dout_valid 2 cycles later.
REQ-037 SHALL cover: rd issued, rst_n low before ROM_LAT elapses -> dout_valid never asserts, dout=8'hFF, registers at reset values.
